fetch_buffer: RTL and testbench



---
 rtl/riscv_pkg.sv | 24 ++
 rtl/fetch_queue_mem.sv | 28 ++
 rtl/fetch_buffer.sv | 150 +++++++++++++++
 tb/tb_fetch_buffer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V front end. The fetch buffer stores two-wide
// fetch packets built from predictor addresses and instruction-memory data.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package riscv_pkg;

  // Instruction word width carried in a fetch packet. The fetch_buffer
  // INSTR_WIDTH parameter defaults to this and must stay equal to it.
  localparam int FB_INSTR_WIDTH = 32;

  // Slots per fetch packet (predictor issues two addresses per cycle).
  localparam int FB_SLOTS = 2;

  // One queue entry: index k of every field belongs to fetch slot k.
  typedef struct packed {
    logic [FB_SLOTS-1:0][`ADDR_WIDTH-1:0]    pc;
    logic [FB_SLOTS-1:0][FB_INSTR_WIDTH-1:0] instr;
    logic [FB_SLOTS-1:0]                     slot_valid;
    logic [FB_SLOTS-1:0]                     pred_branch;
  } fetch_packet_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch-packet storage: one synchronous write port, one combinational read
// port. Contents are not reset; validity is tracked by the pointers/count
// in fetch_buffer.
module fetch_queue_mem
  import riscv_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fetch_packet_t            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fetch_packet_t            rdata
);

  fetch_packet_t mem [DEPTH];

  // Write the enqueued packet into its slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Decoupling queue between next_pc_predictor and decode.
// Stage s1 holds the addresses issued last cycle; they are paired with the
// instruction-memory read data arriving this cycle and written into a
// DEPTH-entry FIFO drained by decode.
//
// Handshake: decode takes the head packet on any cycle where o_valid and
// i_ready are both high; o_valid never depends on i_ready, and the head
// fields are stable until that transfer happens (or a flush/reset).
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int INSTR_WIDTH = FB_INSTR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [`ADDR_WIDTH-1:0]     i_pc [2],
  input  logic                       i_pc_valid [2],
  input  logic                       i_pred_branch [2],
  input  logic [INSTR_WIDTH-1:0]     i_instr [2],
  output logic                       o_stall,
  output logic                       o_valid,
  output logic                       o_slot_valid [2],
  output logic [`ADDR_WIDTH-1:0]     o_pc [2],
  output logic [INSTR_WIDTH-1:0]     o_instr [2],
  output logic                       o_pred_branch [2],
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Alignment stage
  logic [`ADDR_WIDTH-1:0] s1_pc [2];
  logic [1:0]             s1_slot_valid;
  logic [1:0]             s1_pred_branch;
  logic                   s1_valid;

  // Queue bookkeeping
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             enq;
  logic             deq;
  logic [CNT_W:0]   stall_sum;

  fetch_packet_t wr_pkt;
  fetch_packet_t head_pkt;

  assign s1_valid  = |s1_slot_valid;
  assign full      = (count == CNT_W'(DEPTH));

  // Reserve room for the packet already sitting in s1 so it never has to be
  // dropped; depends on registered state only.
  assign stall_sum = {1'b0, count} + (CNT_W + 1)'(s1_valid);
  assign o_stall   = (stall_sum >= (CNT_W + 1)'(DEPTH));

  // A full-queue enqueue is blocked (entry dropped); the stall logic keeps
  // it from ever being attempted.
  assign enq     = s1_valid & ~flush & ~full;
  assign o_valid = (count != '0);
  assign deq     = o_valid & i_ready & ~flush;

  // Capture issued addresses; a stalled or flushed cycle captures nothing so
  // re-presented addresses are never taken twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_pc[0]       <= '0;
      s1_pc[1]       <= '0;
      s1_slot_valid  <= '0;
      s1_pred_branch <= '0;
    end else begin
      s1_pc[0]          <= i_pc[0];
      s1_pc[1]          <= i_pc[1];
      s1_pred_branch[0] <= i_pred_branch[0];
      s1_pred_branch[1] <= i_pred_branch[1];
      s1_slot_valid[0]  <= i_pc_valid[0] & ~o_stall & ~flush;
      s1_slot_valid[1]  <= i_pc_valid[1] & ~o_stall & ~flush;
    end
  end

  // Advance pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pair the s1 addresses with this cycle's instruction-memory data.
  always_comb begin
    wr_pkt                = '0;
    wr_pkt.pc[0]          = s1_pc[0];
    wr_pkt.pc[1]          = s1_pc[1];
    wr_pkt.instr[0]       = i_instr[0];
    wr_pkt.instr[1]       = i_instr[1];
    wr_pkt.slot_valid     = s1_slot_valid;
    wr_pkt.pred_branch    = s1_pred_branch;
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr),
    .wdata (wr_pkt),
    .raddr (rd_ptr),
    .rdata (head_pkt)
  );

  // Present the head packet, forcing all fields to zero when empty.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      o_pc[k]          = '0;
      o_instr[k]       = '0;
      o_slot_valid[k]  = 1'b0;
      o_pred_branch[k] = 1'b0;
      if (o_valid) begin
        o_pc[k]          = head_pkt.pc[k];
        o_instr[k]       = head_pkt.instr[k];
        o_slot_valid[k]  = head_pkt.slot_valid[k];
        o_pred_branch[k] = head_pkt.pred_branch[k];
      end
    end
  end

  assign o_count = count;

  // Writing into a full queue would silently lose a packet.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(s1_valid && !flush && full));

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: a cycle model of count and s1 plus
// an expected-packet queue compared against the head on every cycle.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_fetch_buffer;

  localparam int DEPTH = 8;
  localparam int AW    = `ADDR_WIDTH;
  localparam int IW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int PKW   = 2 * AW + 2 * IW + 4;

  // DUT signals
  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [AW-1:0] i_pc [2];
  logic          i_pc_valid [2];
  logic          i_pred_branch [2];
  logic [IW-1:0] i_instr [2];
  logic          o_stall;
  logic          o_valid;
  logic          o_slot_valid [2];
  logic [AW-1:0] o_pc [2];
  logic [IW-1:0] o_instr [2];
  logic          o_pred_branch [2];
  logic          i_ready;
  logic [CW-1:0] o_count;

  fetch_buffer #(
    .DEPTH       (DEPTH),
    .INSTR_WIDTH (IW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .i_pc          (i_pc),
    .i_pc_valid    (i_pc_valid),
    .i_pred_branch (i_pred_branch),
    .i_instr       (i_instr),
    .o_stall       (o_stall),
    .o_valid       (o_valid),
    .o_slot_valid  (o_slot_valid),
    .o_pc          (o_pc),
    .o_instr       (o_instr),
    .o_pred_branch (o_pred_branch),
    .i_ready       (i_ready),
    .o_count       (o_count)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    reset            = 1'b1;
    flush            = 1'b0;
    i_ready          = 1'b0;
    i_pc[0]          = '0;
    i_pc[1]          = '0;
    i_pc_valid[0]    = 1'b0;
    i_pc_valid[1]    = 1'b0;
    i_pred_branch[0] = 1'b0;
    i_pred_branch[1] = 1'b0;
    i_instr[0]       = '0;
    i_instr[1]       = '0;
  end

  // Scoreboard and model state
  int            vectors;
  int            miscompares;
  logic [PKW-1:0] exp_q [$];
  int            m_count;
  logic [AW-1:0] m_s1_pc [2];
  logic [1:0]    m_s1_sv;
  logic [1:0]    m_s1_pb;
  logic          accepted;
  logic [AW-1:0] next_pc;

  // Per-cycle drive values set by the scenario tasks
  logic [1:0]    d_pv;
  logic [1:0]    d_pb;
  logic [AW-1:0] d_pc0;
  logic [AW-1:0] d_pc1;
  logic          d_ready;
  logic          d_flush;

  function automatic logic [PKW-1:0] pack(input logic [AW-1:0] pc0, input logic [AW-1:0] pc1,
                                          input logic [IW-1:0] in0, input logic [IW-1:0] in1,
                                          input logic [1:0] sv, input logic [1:0] pb);
    return {pc1, pc0, in1, in0, sv, pb};
  endfunction

  // Instruction memory contents as seen by the bench
  function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] pc);
    if (pc == AW'(32'h100)) return 32'h0000_0013;
    if (pc == AW'(32'h104)) return 32'h0010_0093;
    return {pc[15:0] ^ 16'hA5A5, pc[15:0]};
  endfunction

  task automatic set_idle();
    d_pv    = 2'b00;
    d_pb    = 2'b00;
    d_flush = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs against
  // the model, then advance the model to the next cycle.
  task automatic tick(input string tag);
    logic           exp_valid;
    logic           exp_stall;
    logic [PKW-1:0] act;
    logic [PKW-1:0] exp;
    logic [IW-1:0]  in0;
    logic [IW-1:0]  in1;
    logic           enq;
    logic           deq;
    @(negedge clk);
    reset            = 1'b0;
    flush            = d_flush;
    i_ready          = d_ready;
    i_pc[0]          = d_pc0;
    i_pc[1]          = d_pc1;
    i_pc_valid[0]    = d_pv[0];
    i_pc_valid[1]    = d_pv[1];
    i_pred_branch[0] = d_pb[0];
    i_pred_branch[1] = d_pb[1];
    in0              = instr_of(m_s1_pc[0]);
    in1              = instr_of(m_s1_pc[1]);
    i_instr[0]       = in0;
    i_instr[1]       = in1;

    exp_valid = (m_count != 0);
    exp_stall = ((m_count + int'(m_s1_sv != 2'b00)) >= DEPTH);

    vectors++;
    if (o_valid !== exp_valid) begin
      miscompares++;
      $display("FAIL %s o_valid: got %b expected %b", tag, o_valid, exp_valid);
    end
    vectors++;
    if (o_stall !== exp_stall) begin
      miscompares++;
      $display("FAIL %s o_stall: got %b expected %b", tag, o_stall, exp_stall);
    end
    vectors++;
    if (o_count !== CW'(m_count)) begin
      miscompares++;
      $display("FAIL %s o_count: got %0d expected %0d", tag, o_count, m_count);
    end
    act = pack(o_pc[0], o_pc[1], o_instr[0], o_instr[1],
               {o_slot_valid[1], o_slot_valid[0]}, {o_pred_branch[1], o_pred_branch[0]});
    exp = (exp_valid && exp_q.size() > 0) ? exp_q[0] : '0;
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s head: got %h expected %h", tag, act, exp);
    end

    enq = (m_s1_sv != 2'b00) && !d_flush && (m_count < DEPTH);
    deq = exp_valid && d_ready && !d_flush;
    if (d_flush) begin
      exp_q.delete();
      m_count = 0;
    end else begin
      if (deq && exp_q.size() > 0) void'(exp_q.pop_front());
      if (enq) exp_q.push_back(pack(m_s1_pc[0], m_s1_pc[1], in0, in1, m_s1_sv, m_s1_pb));
      m_count = m_count + int'(enq) - int'(deq);
    end
    m_s1_pc[0] = d_pc0;
    m_s1_pc[1] = d_pc1;
    m_s1_pb    = d_pb;
    m_s1_sv    = d_pv & {2{!exp_stall && !d_flush}};
    accepted   = (m_s1_sv != 2'b00);
  endtask

  // Present the next sequential pair; advance only if it was captured.
  task automatic issue(input logic ready, input string tag);
    d_pv    = 2'b11;
    d_pb    = {next_pc[3], next_pc[4]};
    d_pc0   = next_pc;
    d_pc1   = next_pc + AW'(4);
    d_ready = ready;
    d_flush = 1'b0;
    tick(tag);
    if (accepted) next_pc = next_pc + AW'(8);
  endtask

  task automatic drain(input string tag);
    int n;
    set_idle();
    d_ready = 1'b1;
    n = 0;
    while ((m_count != 0 || m_s1_sv != 2'b00) && n < 60) begin
      tick(tag);
      n++;
    end
    tick(tag);
    vectors++;
    if (m_count != 0 || m_s1_sv != 2'b00) begin
      miscompares++;
      $display("FAIL %s drain timeout: model count %0d expected 0", tag, m_count);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset            = 1'b1;
    flush            = 1'b0;
    i_ready          = 1'b0;
    i_pc_valid[0]    = 1'b0;
    i_pc_valid[1]    = 1'b0;
    @(negedge clk);
    exp_q.delete();
    m_count    = 0;
    m_s1_sv    = 2'b00;
    m_s1_pb    = 2'b00;
    m_s1_pc[0] = '0;
    m_s1_pc[1] = '0;
    vectors++;
    if (o_valid !== 1'b0 || o_stall !== 1'b0 || o_count !== '0) begin
      miscompares++;
      $display("FAIL %s status: got valid=%b stall=%b count=%0d expected 0/0/0",
               tag, o_valid, o_stall, o_count);
    end
    vectors++;
    if (o_pc[0] !== '0 || o_pc[1] !== '0 || o_instr[0] !== '0 || o_instr[1] !== '0 ||
        o_slot_valid[0] !== 1'b0 || o_slot_valid[1] !== 1'b0 ||
        o_pred_branch[0] !== 1'b0 || o_pred_branch[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL %s data: got pc0=%h instr0=%h expected all zero", tag, o_pc[0], o_instr[0]);
    end
    set_idle();
    d_ready = 1'b0;
    d_pc0   = '0;
    d_pc1   = '0;
  endtask

  task automatic test_reset();
    do_reset("reset");
    tick("reset_after");
  endtask

  task automatic test_single();
    next_pc = AW'(32'h100);
    issue(1'b1, "single_t");
    d_pb = 2'b00;
    set_idle();
    d_ready = 1'b1;
    tick("single_t1");
    tick("single_t2");
    vectors++;
    if (o_valid !== 1'b1 || o_pc[0] !== AW'(32'h100) || o_pc[1] !== AW'(32'h104) ||
        o_instr[0] !== 32'h0000_0013 || o_instr[1] !== 32'h0010_0093) begin
      miscompares++;
      $display("FAIL single_head: got v=%b pc=%h/%h instr=%h/%h expected 1 100/104 00000013/00100093",
               o_valid, o_pc[0], o_pc[1], o_instr[0], o_instr[1]);
    end
    tick("single_t3");
  endtask

  task automatic test_fill();
    next_pc = AW'(32'h1000);
    for (int i = 0; i < 14; i++) issue(1'b0, "fill");
    vectors++;
    if (o_count !== CW'(DEPTH) || o_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_full: got count=%0d stall=%b expected %0d 1", o_count, o_stall, DEPTH);
    end
    drain("fill_drain");
  endtask

  task automatic test_wrap();
    int n;
    int guard;
    next_pc = AW'(32'h2000);
    n = 0;
    guard = 0;
    while (n < 20 && guard < 200) begin
      issue(guard[0], "wrap");
      if (accepted) n++;
      guard++;
    end
    vectors++;
    if (n != 20) begin
      miscompares++;
      $display("FAIL wrap_issue: got %0d packets expected 20", n);
    end
    drain("wrap_drain");
  endtask

  task automatic test_flush_load();
    int guard;
    next_pc = AW'(32'h3000);
    guard = 0;
    while (!(m_count == 5 && m_s1_sv != 2'b00) && guard < 20) begin
      issue(1'b0, "flush_fill");
      guard++;
    end
    d_pv    = 2'b11;
    d_pc0   = AW'(32'h3F00);
    d_pc1   = AW'(32'h3F04);
    d_ready = 1'b1;
    d_flush = 1'b1;
    tick("flush_cycle");
    vectors++;
    if (o_count !== CW'(5)) begin
      miscompares++;
      $display("FAIL flush_setup: got count=%0d expected 5", o_count);
    end
    next_pc = AW'(32'h200);
    issue(1'b0, "flush_t1");
    vectors++;
    if (o_count !== '0 || o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_empty: got count=%0d valid=%b expected 0 0", o_count, o_valid);
    end
    set_idle();
    d_ready = 1'b0;
    tick("flush_t2");
    tick("flush_t3");
    vectors++;
    if (o_valid !== 1'b1 || o_pc[0] !== AW'(32'h200)) begin
      miscompares++;
      $display("FAIL flush_new: got valid=%b pc0=%h expected 1 200", o_valid, o_pc[0]);
    end
    drain("flush_drain");
  endtask

  task automatic test_slot_flags();
    d_pv    = 2'b01;
    d_pb    = 2'b01;
    d_pc0   = AW'(32'h300);
    d_pc1   = AW'(32'h304);
    d_ready = 1'b0;
    d_flush = 1'b0;
    tick("slot_issue");
    set_idle();
    tick("slot_t1");
    tick("slot_t2");
    vectors++;
    if (o_slot_valid[0] !== 1'b1 || o_slot_valid[1] !== 1'b0 ||
        o_pred_branch[0] !== 1'b1 || o_pred_branch[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL slot_flags: got sv=%b%b pb=%b%b expected sv=01 pb=01",
               o_slot_valid[1], o_slot_valid[0], o_pred_branch[1], o_pred_branch[0]);
    end
    drain("slot_drain");
  endtask

  task automatic test_reset_mid();
    int guard;
    next_pc = AW'(32'h4000);
    guard = 0;
    while (m_count != 3 && guard < 20) begin
      issue(1'b0, "rmid_fill");
      guard++;
    end
    do_reset("rmid_reset");
    next_pc = AW'(32'h5000);
    issue(1'b0, "rmid_new");
    issue(1'b0, "rmid_new");
    drain("rmid_drain");
  endtask

  task automatic test_random();
    for (int i = 0; i < 120; i++) begin
      d_pv    = 2'($urandom_range(0, 3));
      d_pb    = 2'($urandom_range(0, 3));
      d_pc0   = AW'($urandom_range(0, 32'hFFFF)) & ~AW'(3);
      d_pc1   = d_pc0 + AW'(4);
      d_ready = ($urandom_range(0, 2) != 0) ? (i > 60) : 1'b0;
      d_flush = ($urandom_range(0, 19) == 0);
      tick("random");
    end
    drain("random_drain");
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_count     = 0;
    m_s1_sv     = 2'b00;
    m_s1_pb     = 2'b00;
    m_s1_pc[0]  = '0;
    m_s1_pc[1]  = '0;
    accepted    = 1'b0;
    next_pc     = '0;
    set_idle();
    d_ready     = 1'b0;
    d_pc0       = '0;
    d_pc1       = '0;
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_flush_load();
    test_slot_flags();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
